// File: rtl/cordic_sequencer.sv
// rtl/cordic_sequencer.sv - Nios custom-instruction sequencer for the iterative CORDIC cosine core
// Holds the operand, unpacks it to a Q0.32 angle and steps the CORDIC datapath.

module unpacker (
   input  logic [30:0] mag_i,
   output logic [31:0] z_o,
   output logic        is_special_o
);

   logic [7:0]  exp_w;
   logic [23:0] mant_w;
   logic [55:0] wide_w;
   logic [7:0]  shamt_w;

   assign exp_w   = mag_i[30:23];
   assign mant_w  = {1'b1, mag_i[22:0]};
   assign wide_w  = {mant_w, 32'h0};
   assign shamt_w = 8'd150 - exp_w;

   // |x| >= 1.0 (including Inf/NaN) lies outside the Q0.32 angle range; denormals flush to zero.
   always_comb begin
      z_o          = 32'h0;
      is_special_o = 1'b0;
      if (exp_w >= 8'd127) begin
         is_special_o = 1'b1;
      end else if (exp_w != 8'd0 && shamt_w < 8'd56) begin
         z_o = 32'(wide_w >> shamt_w);
      end
   end

endmodule

module cordic_sequencer #(
   parameter int          ITERS          = 16,
   parameter int          IDX_W          = 5,
   parameter logic [31:0] SPECIAL_RESULT = 32'h0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             start,
   input  logic [31:0]      dataa,
   output logic [31:0]      result,
   output logic             done,
   output logic             busy,
   output logic             dp_load,
   output logic [31:0]      dp_z0,
   output logic             dp_sign,
   output logic             dp_step,
   output logic [IDX_W-1:0] dp_iter,
   input  logic [31:0]      dp_result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERS - 1);

   logic [1:0]       state_q,  state_d;
   logic [IDX_W-1:0] cnt_q,    cnt_d;
   logic [30:0]      op_q,     op_d;
   logic             sign_q,   sign_d;
   logic [31:0]      result_q, result_d;

   logic [31:0] z_w;
   logic        special_w;

   unpacker u_unpacker (
      .mag_i        (op_q),
      .z_o          (z_w),
      .is_special_o (special_w)
   );

   // op_q is stable from LOAD through DONE, so special_w still tells the two DONE paths apart.
   assign result  = (state_q == S_DONE && !special_w) ? dp_result : result_q;
   assign done    = (state_q == S_DONE);
   assign busy    = (state_q != S_IDLE);
   assign dp_load = (state_q == S_LOAD) && !special_w;
   assign dp_step = (state_q == S_ITER);
   assign dp_iter = cnt_q;
   assign dp_sign = sign_q;
   assign dp_z0   = z_w;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sign_d   = sign_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = dataa[30:0];
               sign_d  = dataa[31];
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (special_w) begin
               result_d = SPECIAL_RESULT;
               state_d  = S_DONE;
            end else begin
               cnt_d   = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            if (cnt_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            result_d = result;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         sign_q   <= 1'b0;
         result_q <= 32'h0;
      end else if (clk_en) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sign_q   <= sign_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_cordic_sequencer.sv
// tb/tb_cordic_sequencer.sv - scoreboard bench for cordic_sequencer with a toy datapath model

module tb_cordic_sequencer;

   localparam int          ITERS = 16;
   localparam logic [31:0] KEY   = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dataa = 32'h0;
   logic [31:0] result;
   logic        done;
   logic        busy;
   logic        dp_load;
   logic [31:0] dp_z0;
   logic        dp_sign;
   logic        dp_step;
   logic [4:0]  dp_iter;
   logic [31:0] dp_result;
   logic [31:0] acc = 32'h0;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_res_q[$];
   int          exp_lat_q[$];

   always #5 clk = ~clk;

   cordic_sequencer #(.ITERS(ITERS), .IDX_W(5), .SPECIAL_RESULT(32'h0)) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .start     (start),
      .dataa     (dataa),
      .result    (result),
      .done      (done),
      .busy      (busy),
      .dp_load   (dp_load),
      .dp_z0     (dp_z0),
      .dp_sign   (dp_sign),
      .dp_step   (dp_step),
      .dp_iter   (dp_iter),
      .dp_result (dp_result)
   );

   // Toy datapath: load seeds z0^KEY, each step adds iter+1.
   always @(posedge clk) begin
      if (reset) acc <= 32'h0;
      else if (clk_en) begin
         if (dp_load) acc <= dp_z0 ^ KEY;
         else if (dp_step) acc <= acc + 32'(dp_iter) + 32'd1;
      end
   end
   assign dp_result = acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode: 0 plain, 1 clk_en stall at iter 7, 2 reset abort at iter 7, 3 extra start during ITER
   task automatic run_op(input logic [31:0] a, input logic [31:0] z0, input bit spec, input int mode);
      int          k;
      int          steps;
      int          loads;
      int          dones;
      int          extra;
      bit          stalled;
      logic [31:0] prev;
      logic [31:0] er;
      int          el;
      steps = 0; loads = 0; dones = 0; extra = 0; stalled = 0;
      if (mode != 2) begin
         exp_res_q.push_back(spec ? 32'h0 : ((z0 ^ KEY) + 32'd136));
         exp_lat_q.push_back(spec ? 2 : (mode == 1 ? 21 : 18));
      end
      prev  = result;
      dataa = a;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 1;
      chk("dp_sign", {31'h0, dp_sign}, {31'h0, a[31]});
      chk("load_at_t1", {31'h0, dp_load}, spec ? 32'h0 : 32'h1);
      if (!spec) chk("dp_z0", dp_z0, z0);
      while (k <= 40 && dones == 0) begin
         chk("load_step_excl", {31'h0, dp_load & dp_step}, 32'h0);
         if (dp_load) loads++;
         if (dp_step) begin
            chk("dp_iter", {27'h0, dp_iter}, steps);
            steps++;
            if (mode == 1 && dp_iter == 5'd7 && !stalled) begin
               stalled = 1;
               clk_en = 1'b0;
               repeat (3) begin
                  tick();
                  k++;
                  chk("stall_iter", {27'h0, dp_iter}, 32'd7);
                  chk("stall_result", result, prev);
               end
               clk_en = 1'b1;
            end
            if (mode == 2 && dp_iter == 5'd7) begin
               reset = 1'b1;
               tick();
               reset = 1'b0;
               chk("abort_busy", {31'h0, busy}, 32'h0);
               chk("abort_done", {31'h0, done}, 32'h0);
               chk("abort_result", result, 32'h0);
               repeat (20) begin
                  tick();
                  if (done) extra++;
               end
               chk("abort_no_done", extra, 0);
               return;
            end
            if (mode == 3 && dp_iter == 5'd3) begin
               dataa = 32'h3F80_0000;
               start = 1'b1;
            end
         end
         if (done) begin
            dones = 1;
            chk("sb_nonempty", exp_res_q.size(), 1);
            if (exp_res_q.size() > 0) begin
               er = exp_res_q.pop_front();
               el = exp_lat_q.pop_front();
               chk("latency", k, el);
               chk("result", result, er);
               chk("step_count", steps, spec ? 0 : ITERS);
               chk("load_count", loads, spec ? 0 : 1);
               tick();
               chk("result_held", result, er);
               chk("busy_after", {31'h0, busy}, 32'h0);
               chk("done_one_cycle", {31'h0, done}, 32'h0);
            end
         end else begin
            tick();
            start = 1'b0;
            k++;
         end
      end
      chk("done_seen", dones, 1);
      if (mode == 3) begin
         repeat (25) begin
            tick();
            if (done) extra++;
         end
         chk("single_done", extra, 0);
      end
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b1;
      dataa  = 32'h3F00_0000;
      repeat (2) tick();
      chk("rst_result", result, 32'h0);
      chk("rst_flags", {26'h0, done, busy, dp_load, dp_step, dp_sign, 1'b0}, 32'h0);
      chk("rst_iter", {27'h0, dp_iter}, 32'h0);
      reset = 1'b0;
      start = 1'b0;
      repeat (5) begin
         tick();
         chk("idle_quiet", {29'h0, done, dp_load, dp_step}, 32'h0);
      end

      run_op(32'h3F00_0000, 32'h8000_0000, 1'b0, 0);
      run_op(32'hBF00_0000, 32'h8000_0000, 1'b0, 0);
      run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 0);
      run_op(32'h3F80_0000, 32'h0000_0000, 1'b1, 0);
      run_op(32'h3E80_0000, 32'h4000_0000, 1'b0, 1);
      run_op(32'h3F00_0000, 32'h8000_0000, 1'b0, 2);
      run_op(32'h3F40_0000, 32'hC000_0000, 1'b0, 3);
      run_op(32'h3F00_0000, 32'h8000_0000, 1'b0, 0);

      chk("sb_drained", exp_res_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cordic_sequencer.md
Name: cordic_sequencer

Overview:
- Multi-cycle Nios II custom-instruction controller for the iterative CORDIC cosine core.
- Captures the IEEE-754 single operand and converts it to the fixed-point angle with the existing `unpacker`, instantiated internally.
- Drives the iterative CORDIC datapath through load/step/index signals, bypasses it for the unpacker's special-range inputs, and returns the result with a one-cycle `done`.
- Sits between the Nios custom-instruction port and the CORDIC stage datapath.

Parameters:
- ITERS, 16, number of CORDIC micro-rotations per operation; legal range 1..31.
- IDX_W, 5, width of `dp_iter`; must satisfy 2^IDX_W > ITERS-1.
- SPECIAL_RESULT, 32'h0, value returned for special-range operands (unpacker isSpecial).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  Nios clock enable; when low, all registers hold.
- start  in  1  operation request; sampled in IDLE only.
- dataa  in  32  IEEE-754 single-precision angle operand.
- result  out  32  operation result; valid when `done`=1, held until the next `done`.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- dp_load  out  1  datapath initial-value load strobe.
- dp_z0  out  32  unpacked fixed-point angle; valid while `dp_load`=1.
- dp_sign  out  1  operand sign bit, registered at start.
- dp_step  out  1  perform one micro-rotation this cycle.
- dp_iter  out  IDX_W  current micro-rotation index.
- dp_result  in  32  datapath output; valid on the cycle after the last `dp_step`.

Behaviour:
- Reset (synchronous, wins over everything including clk_en=0):
  - State goes to IDLE.
  - `result`=0, `done`=0, `busy`=0, `dp_load`=0, `dp_step`=0, `dp_iter`=0, `dp_sign`=0, operand register=0.
- clk_en=0: state, counter, operand register and all outputs frozen. No `done` is generated or dropped; the pending pulse is simply delayed.
- States: IDLE, LOAD, ITER, DONE. All outputs are decoded from, or held in, registered state (Moore-style).
- IDLE:
  - If start=1 (and clk_en=1) at edge T: capture `dataa` into the operand register and `dataa[31]` into `dp_sign`; go to LOAD at T+1.
  - Otherwise remain in IDLE.
- LOAD (cycle T+1):
  - The internal unpacker is fed from the operand register.
  - If its isSpecial output=0: `dp_load`=1, `dp_z0`=unpacker result; clear the counter; go to ITER.
  - If isSpecial=1: `dp_load`=0; load SPECIAL_RESULT into `result`; go to DONE.
  - `dp_z0` is driven from the unpacker in every state; it is meaningful only when `dp_load`=1.
- ITER (cycles T+2 .. T+1+ITERS):
  - `dp_step`=1 and `dp_iter`=counter; the counter increments 0..ITERS-1.
  - At counter==ITERS-1: go to DONE; the counter does not wrap.
- DONE (normal path, cycle T+2+ITERS):
  - `done`=1; `result` takes `dp_result` on this cycle (combinational into `result` while in DONE, registered at the edge so it stays held afterwards).
  - Next state is IDLE.
- Latency from the start edge to `done`: ITERS+2 cycles on the normal path (18 at default), 2 cycles on the special path. Back-to-back issue: the next start is accepted on the cycle after DONE.
- start while busy=1: ignored; no queuing.
- Zero operand: the unpacker yields 0 with isSpecial=0, so the full iteration path runs.
- Reset mid-operation: next cycle is IDLE, no `done`, `result` cleared to 0.
- `dp_load` and `dp_step` are never high together; each is high at most once per cycle of its state.

Test Plan:
- Reset checks:
  - Assert reset for 2 cycles with start=1 → all outputs 0, busy=0.
  - Release reset, idle 5 cycles → no `dp_load`, `dp_step` or `done`.
- Normal operand: dataa=32'h3F000000 (0.5), start at T:
  - T+1: `dp_load`=1, `dp_z0`=32'h80000000, `dp_sign`=0.
  - T+2..T+17: `dp_step`=1 with `dp_iter`=0..15.
  - T+18: `done`=1, `result`=the `dp_result` value driven by the bench model.
- Negative and zero operands:
  - dataa=32'hBF000000 → `dp_sign`=1, `dp_z0`=32'h80000000.
  - dataa=0 → `dp_z0`=0, full 16 steps, `done` at T+18.
- Special operand: dataa=32'h3F800000 (1.0) → `dp_load` and `dp_step` never assert; `done` at T+2 with `result`=SPECIAL_RESULT.
- clk_en stall: drop clk_en for 3 cycles while `dp_iter`=7 → `dp_iter` holds at 7, `done` moves to T+21, `result` unchanged.
- Abort and busy handling:
  - Assert reset while `dp_iter`=7 → IDLE next cycle, `done` never pulses, `result`=0.
  - A second start pulse during ITER is ignored; exactly one `done` is produced.
